stage_sequencer: RTL
====================

Name: stage_sequencer

Overview:
- Multi-cycle control sequencer for the RV32I core. It owns the per-instruction phase schedule that fetch, decode, execute, memory and writeback stages currently derive from private clock counters.
- It drives one-hot stage enables and stretches the memory phase until data memory is ready.
- It handles run/halt control and a memory timeout, and counts retired instructions.
- Sits at core top level, beside the stage modules; purely control, no datapath.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles spent waiting for mem_ready_i in MEM before timeout; legal range 1..255.
- CNT_W, 32: width of instruction and performance counters.

Ports:
- clk_i  in  1  core clock, rising-edge.
- reset_ni  in  1  asynchronous, active-low reset.
- run_i  in  1  level; start or continue issuing instructions.
- halt_i  in  1  level; request stop after the current instruction retires.
- fetch_ready_i  in  1  instruction word valid from instruction memory.
- mem_req_i  in  1  current instruction uses data memory; sampled in EXEC.
- mem_ready_i  in  1  data memory access complete.
- fetch_en_o  out  1  fetch stage enable.
- decode_en_o  out  1  decode stage enable.
- execute_en_o  out  1  execute stage enable.
- memory_en_o  out  1  memory stage enable.
- writeback_en_o  out  1  writeback stage enable.
- state_o  out  3  current state encoding.
- busy_o  out  1  high in FETCH..WB.
- retire_o  out  1  one-cycle pulse in WB.
- err_timeout_o  out  1  sticky memory-timeout flag.
- instr_cnt_o  out  CNT_W  retired instruction count.

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encoding 7 is illegal and recovers to IDLE next cycle.
- Moore outputs decoded from the state register. Exactly one stage enable is high in each of FETCH..WB; all enables are low in IDLE and HALT.
- Reset (async assert, sync release): state=IDLE; all enables, retire_o, err_timeout_o, halt_pend, mem_req_q and wait_cnt=0; instr_cnt_o=0.
- Reset asserted mid-instruction: abort immediately, no retire, counters cleared.
- IDLE -> FETCH when run_i=1, else stay.
- FETCH: hold until fetch_ready_i=1, then DECODE. No timeout in FETCH.
- DECODE -> EXEC after exactly 1 cycle.
- EXEC -> MEM after exactly 1 cycle. mem_req_q <= mem_req_i at the EXEC clock edge.
- MEM, mem_req_q=0: exactly 1 cycle, then WB.
- MEM, mem_req_q=1: wait_cnt increments each cycle mem_ready_i=0.
  - mem_ready_i=1 -> WB, even on the same cycle wait_cnt reaches MEM_TIMEOUT (ready wins).
  - wait_cnt==MEM_TIMEOUT with ready low -> set err_timeout_o, go to HALT, no retire.
  - wait_cnt clears on entering MEM.
- WB: 1 cycle. retire_o=1 and instr_cnt_o increments, wrapping at 2^CNT_W-1 -> 0.
- WB next state:
  - halt_pend or halt_i -> HALT.
  - else run_i -> FETCH (back-to-back instructions, no bubble).
  - else IDLE.
- halt_i high in any FETCH..MEM cycle sets halt_pend. The in-flight instruction always completes. halt_i in IDLE -> HALT directly.
- HALT is absorbing; exit only by reset. run_i is ignored there.
- Minimum latency per instruction is 5 cycles (FETCH..WB) with fetch_ready_i and mem_ready_i both 1.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt_o[CNT_W] and stall_cnt_o[CNT_W], both reset to 0 and wrapping.
  - cycle_cnt_o increments every cycle busy_o=1.
  - stall_cnt_o increments every cycle in FETCH with fetch_ready_i=0, or in MEM with mem_req_q=1 and mem_ready_i=0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset release, run_i=1, fetch_ready_i=1, mem_req_i=0: state_o sequence 1,2,3,4,5,1; retire_o pulses every 5 cycles; instr_cnt_o=4 after 20 cycles.
- mem_req_i=1, mem_ready_i rising 3 cycles after MEM entry: memory_en_o high 4 cycles, then WB; err_timeout_o=0. With SEQ_PERF_CNT_EN, stall_cnt_o=3.
- mem_req_i=1, mem_ready_i stuck 0, MEM_TIMEOUT=4: HALT after 4 MEM wait cycles; err_timeout_o=1; no retire_o; instr_cnt_o unchanged.
- halt_i pulsed 1 cycle during DECODE: instruction completes (retire_o=1), then state_o=6; run_i=1 ignored thereafter until reset_ni low.
- reset_ni dropped mid-MEM, asynchronously off-edge: outputs 0 and state_o=0 before the next clk_i edge; instr_cnt_o=0.
- Wrap check with CNT_W=4: 16 retirements -> instr_cnt_o returns to 0. Also force illegal state 7: recovers to IDLE within 1 cycle.

Source files
------------

// File: rtl/stage_sequencer_if.sv
// Control bundle between the stage sequencer and the RV32I stage modules.
// Signals:
//   run_i, halt_i         : run/halt control levels into the sequencer
//   fetch_ready_i         : instruction word valid
//   mem_req_i, mem_ready_i: data memory request (sampled in EXEC) / completion
//   *_en_o                : one-hot stage enables
//   state_o, busy_o       : current state and busy indication
//   retire_o              : one-cycle retire pulse
//   err_timeout_o         : sticky memory-timeout flag
//   instr_cnt_o           : retired instruction count
//   cycle_cnt_o, stall_cnt_o : performance counters, present with SEQ_PERF_CNT_EN
// master modport: sequencer side. slave modport: core/stage side.
interface stage_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic             run_i;
  logic             halt_i;
  logic             fetch_ready_i;
  logic             mem_req_i;
  logic             mem_ready_i;
  logic             fetch_en_o;
  logic             decode_en_o;
  logic             execute_en_o;
  logic             memory_en_o;
  logic             writeback_en_o;
  logic [2:0]       state_o;
  logic             busy_o;
  logic             retire_o;
  logic             err_timeout_o;
  logic [CNT_W-1:0] instr_cnt_o;
`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [CNT_W-1:0] stall_cnt_o;
`endif

  modport master (
    input  run_i, halt_i, fetch_ready_i, mem_req_i, mem_ready_i,
    output fetch_en_o, decode_en_o, execute_en_o, memory_en_o, writeback_en_o,
    output state_o, busy_o, retire_o, err_timeout_o, instr_cnt_o
`ifdef SEQ_PERF_CNT_EN
    , output cycle_cnt_o, stall_cnt_o
`endif
  );

  modport slave (
    output run_i, halt_i, fetch_ready_i, mem_req_i, mem_ready_i,
    input  fetch_en_o, decode_en_o, execute_en_o, memory_en_o, writeback_en_o,
    input  state_o, busy_o, retire_o, err_timeout_o, instr_cnt_o
`ifdef SEQ_PERF_CNT_EN
    , input cycle_cnt_o, stall_cnt_o
`endif
  );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle phase sequencer for the RV32I core: walks each instruction
// through FETCH, DECODE, EXEC, MEM, WB, drives one-hot stage enables, stretches
// MEM until data memory is ready (bounded by MEM_TIMEOUT), handles run/halt and
// counts retired instructions.
// Ports:
//   clk_i    : core clock, rising edge
//   reset_ni : asynchronous active-low reset (release assumed synchronised upstream)
//   seq_if   : stage_sequencer_if.master control bundle
// Optional feature: define SEQ_PERF_CNT_EN to add cycle_cnt_o / stall_cnt_o.
// Every output is a flop; enables/busy/retire are registered from the
// next-state decode so they line up with state_o.
module stage_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  stage_sequencer_if.master seq_if
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned EN_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  // Plain vector so the unused encoding 7 is representable and recoverable.
  logic [2:0]        state_q;
  state_e            state_d;
  logic              halt_pend_q, halt_pend_d;
  logic              mem_req_q, mem_req_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
  logic [EN_W-1:0]   en_q, en_d;
  logic              busy_q, busy_d;
  logic              retire_q, retire_d;

  // State and status registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      halt_pend_q <= 1'b0;
      mem_req_q   <= 1'b0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      instr_cnt_q <= '0;
      en_q        <= '0;
      busy_q      <= 1'b0;
      retire_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_pend_q <= halt_pend_d;
      mem_req_q   <= mem_req_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      instr_cnt_q <= instr_cnt_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      retire_q    <= retire_d;
    end
  end

  // Next-state logic and registered-output decode.
  always_comb begin
    state_d     = ST_IDLE;
    halt_pend_d = halt_pend_q;
    mem_req_d   = mem_req_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    instr_cnt_d = instr_cnt_q;
    en_d        = '0;
    busy_d      = 1'b0;
    retire_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (seq_if.halt_i)     state_d = ST_HALT;
        else if (seq_if.run_i) state_d = ST_FETCH;
        else                   state_d = ST_IDLE;
      end
      ST_FETCH:  state_d = seq_if.fetch_ready_i ? ST_DECODE : ST_FETCH;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d    = ST_MEM;
        mem_req_d  = seq_if.mem_req_i;
        wait_cnt_d = '0;
      end
      ST_MEM: begin
        // Ready wins over a timeout reached in the same cycle.
        if (!mem_req_q || seq_if.mem_ready_i) begin
          state_d = ST_WB;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (wait_cnt_d == WAIT_W'(MEM_TIMEOUT)) begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end else begin
            state_d = ST_MEM;
          end
        end
      end
      ST_WB: begin
        if (halt_pend_q || seq_if.halt_i) state_d = ST_HALT;
        else if (seq_if.run_i)            state_d = ST_FETCH;
        else                              state_d = ST_IDLE;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase

    // A halt seen mid-instruction is deferred until WB.
    if (seq_if.halt_i && (state_q == ST_FETCH || state_q == ST_DECODE ||
                          state_q == ST_EXEC  || state_q == ST_MEM)) begin
      halt_pend_d = 1'b1;
    end

    // Count on WB entry so instr_cnt_o and retire_o update together.
    if (state_d == ST_WB) begin
      instr_cnt_d = instr_cnt_q + CNT_W'(1);
    end

    case (state_d)
      ST_FETCH:  en_d = 5'b00001;
      ST_DECODE: en_d = 5'b00010;
      ST_EXEC:   en_d = 5'b00100;
      ST_MEM:    en_d = 5'b01000;
      ST_WB:     en_d = 5'b10000;
      default:   en_d = '0;
    endcase
    busy_d   = (en_d != '0);
    retire_d = (state_d == ST_WB);
  end

  assign seq_if.fetch_en_o     = en_q[0];
  assign seq_if.decode_en_o    = en_q[1];
  assign seq_if.execute_en_o   = en_q[2];
  assign seq_if.memory_en_o    = en_q[3];
  assign seq_if.writeback_en_o = en_q[4];
  assign seq_if.state_o        = state_q;
  assign seq_if.busy_o         = busy_q;
  assign seq_if.retire_o       = retire_q;
  assign seq_if.err_timeout_o  = err_q;
  assign seq_if.instr_cnt_o    = instr_cnt_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Busy-cycle and stall-cycle counters.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (busy_q) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    if ((state_q == ST_FETCH && !seq_if.fetch_ready_i) ||
        (state_q == ST_MEM && mem_req_q && !seq_if.mem_ready_i)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign seq_if.cycle_cnt_o = cycle_cnt_q;
  assign seq_if.stall_cnt_o = stall_cnt_q;
`endif

endmodule
